// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uartTX among N_REQ valid/ready byte producers.
// Optional multi-byte packet lock is built in when the macro UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int TO_CYCLES = 2*10*CLK_RATE/BAUD_RATE
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   req_lock_i,
`endif
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  input  logic               tx_rdy_i,
  input  logic               tx_done_i,
  output logic               tx_en_o,
  output logic [7:0]         tx_data_o,
  output logic               busy_o,
  output logic               err_o
);

  // state     | meaning
  // ST_IDLE   | no owner; arbitrate when any request is valid and uartTX is ready
  // ST_LAUNCH | byte latched, tx_en_o high for this single cycle, watchdog cleared
  // ST_WAIT   | frame in flight; leave on tx_done_i or on watchdog expiry
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TO_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TO_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = {WW{1'b1}};

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;
  logic               win_found;
  logic               accept;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   win_oh;
  logic [WW-1:0]      wd;

`ifdef UART_ARB_LOCK_EN
  logic               lock_q;
  logic [N_REQ-1:0]   lock_mask;

  // While a packet is locked only its owner may win, even if it is momentarily idle.
  assign eligible = lock_q ? (req_valid_i & lock_mask) : req_valid_i;
`else
  assign eligible = req_valid_i;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh      = N_REQ'(1) << win_idx;
  assign ptr_next    = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
  assign accept      = (state == ST_IDLE) && tx_rdy_i && win_found;
  assign req_ready_o = accept ? win_oh : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      wd        <= '0;
      grant_o   <= '0;
      tx_en_o   <= 1'b0;
      tx_data_o <= '0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_mask <= '0;
`endif
    end else begin
      tx_en_o <= 1'b0;
      err_o   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_data_o <= req_data_i[{win_idx, 3'b000} +: 8];
            grant_o   <= win_oh;
            tx_en_o   <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_LAUNCH;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= req_lock_i[win_idx];
            lock_mask <= win_oh;
            if (!req_lock_i[win_idx]) ptr <= ptr_next;
`else
            ptr       <= ptr_next;
`endif
          end
        end
        ST_LAUNCH: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is tested first so a coincident timeout never raises err_o
          if (tx_done_i) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else if (wd == WD_LAST) begin
            err_o   <= 1'b1;
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
          end else if (wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producers and a uartTX stand-in drive the DUT,
// expected grants/bytes are queued by the stimulus and checked on every tx_en_o pulse.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 50;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]   req_lock = '0;
  logic           lq [N][$];
`endif
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_rdy = 1'b0;
  logic           tx_done;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic           busy;
  logic           err;

  logic           done_auto = 1'b0;
  logic           done_man = 1'b0;
  bit             done_en = 1'b0;
  int             done_dly = 5;
  int             dcnt = 0;

  logic [7:0]     pq [N][$];
  exp_t           exp_q [$];
  logic [N-1:0]   acc = '0;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int ready_cyc = -10;
  int en_cnt = 0;
  int err_cnt = 0;
  int t_launch = 0;
  int n = 0;

  assign tx_done = done_auto | done_man;

  uart_tx_arbiter #(
    .N_REQ(N), .CLK_RATE(100000000), .BAUD_RATE(9600), .TO_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock_i(req_lock),
`endif
    .req_ready_o(req_ready),
    .grant_o(grant),
    .tx_rdy_i(tx_rdy),
    .tx_done_i(tx_done),
    .tx_en_o(tx_en),
    .tx_data_o(tx_data),
    .busy_o(busy),
    .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Producers: present queue heads after each negedge, note acceptance just before posedge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (acc[k] && pq[k].size() > 0) begin
        void'(pq[k].pop_front());
`ifdef UART_ARB_LOCK_EN
        if (lq[k].size() > 0) void'(lq[k].pop_front());
`endif
      end
    end
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (pq[k].size() > 0);
      req_data[8*k +: 8] = (pq[k].size() > 0) ? pq[k][0] : 8'h00;
`ifdef UART_ARB_LOCK_EN
      req_lock[k]        = (lq[k].size() > 0) ? lq[k][0] : 1'b0;
`endif
    end
    #4;
    acc = req_ready;
    if (req_ready != '0) ready_cyc = cyc_cnt;
  end

  // uartTX stand-in: done pulse done_dly cycles after each tx_en when enabled.
  always @(negedge clk) begin
    done_auto = 1'b0;
    if (!rst_n) dcnt = 0;
    else if (tx_en && done_en) dcnt = done_dly;
    else if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) done_auto = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever a byte is launched.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tx_en) begin
      en_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_tx_en", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_grant", 32'(grant), 32'(1) << e.idx);
        chk("sb_tx_data", 32'(tx_data), 32'(e.data));
        chk("sb_en_latency", cyc_cnt - ready_cyc, 1);
      end
    end
    if (req_ready != '0) begin
      chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      chk("ready_only_idle", 32'(busy), 32'd0);
    end
    if (rst_n && err) err_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    pq[k].push_back(d);
`ifdef UART_ARB_LOCK_EN
    lq[k].push_back(1'b0);
`endif
  endtask

  task automatic expect_byte(input int k, input logic [7:0] d);
    exp_t e;
    e.idx  = 8'(k);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += pq[k].size();
    return s;
  endfunction

  task automatic wait_en(input string name);
    int m = 0;
    step();
    while (!tx_en && m < 40) begin
      step();
      m++;
    end
    chk(name, 32'(tx_en), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int m = 0;
    bit idle = 1'b0;
    while (!idle && m < max) begin
      step();
      m++;
      idle = !busy && (exp_q.size() == 0) && (pending() == 0);
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    // reset state
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // all four valid, done 20 cycles after tx_en: order 0,1,2,3,0
    tx_rdy = 1'b1; done_en = 1'b1; done_dly = 20;
    send(0, 8'h10); send(1, 8'h11); send(2, 8'h12); send(3, 8'h13); send(0, 8'h14);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    expect_byte(3, 8'h13); expect_byte(0, 8'h14);
    wait_idle("t2_complete", 400);
    chk("t2_launch_count", en_cnt, 5);

    // single requester, A5
    done_dly = 5;
    send(0, 8'hA5); expect_byte(0, 8'hA5);
    wait_en("t1_tx_en");
    chk("t1_grant_launch", 32'(grant), 32'b0001);
    chk("t1_busy_launch", 32'(busy), 32'd1);
    n = 0;
    while (!tx_done && n < 20) begin
      step();
      n++;
      chk("t1_grant_hold", 32'(grant), 32'b0001);
    end
    chk("t1_done_seen", 32'(tx_done), 32'd1);
    step();
    chk("t1_busy_after_done", 32'(busy), 32'd0);
    chk("t1_grant_after_done", 32'(grant), 32'd0);

    // uartTX not ready: nothing accepted until tx_rdy rises
    tx_rdy = 1'b0;
    send(2, 8'hC3); expect_byte(2, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_no_ready", 32'(req_ready), 32'd0);
      chk("t3_no_tx_en", 32'(tx_en), 32'd0);
    end
    tx_rdy = 1'b1;
    #1;
    chk("t3_ready_same_cycle", 32'(req_ready), 32'b0100);
    step();
    chk("t3_tx_en_next", 32'(tx_en), 32'd1);
    wait_idle("t3_complete", 40);

    // watchdog: WAIT_DONE spans TO cycles, err_o in the first cycle back in IDLE
    done_en = 1'b0;
    send(3, 8'h3C); expect_byte(3, 8'h3C);
    wait_en("t4_tx_en");
    t_launch = cyc_cnt;
    n = 0;
    while (!err && n < 100) begin
      step();
      n++;
    end
    chk("t4_err_seen", 32'(err), 32'd1);
    chk("t4_err_latency", cyc_cnt - t_launch, TO + 1);
    chk("t4_grant_cleared", 32'(grant), 32'd0);
    chk("t4_busy_cleared", 32'(busy), 32'd0);
    step();
    chk("t4_err_one_cycle", 32'(err), 32'd0);
    done_en = 1'b1;
    send(1, 8'h5A); expect_byte(1, 8'h5A);
    wait_idle("t4_next_served", 60);
    chk("t4_err_count", err_cnt, 1);

    // done arriving in the last watchdog cycle wins over the timeout
    done_en = 1'b0;
    send(0, 8'h77); expect_byte(0, 8'h77);
    wait_en("tw_tx_en");
    repeat (TO) step();
    done_man = 1'b1;
    step();
    done_man = 1'b0;
    chk("tw_idle_after_done", 32'(busy), 32'd0);
    chk("tw_no_err", 32'(err), 32'd0);
    step();
    chk("tw_no_err_late", 32'(err), 32'd0);
    chk("tw_err_count", err_cnt, 1);

    // reset during WAIT_DONE
    send(2, 8'h99); expect_byte(2, 8'h99);
    wait_en("t5_tx_en");
    repeat (3) step();
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_no_err_after", 32'(err), 32'd0);
    // pointer back at 0: req1 must beat req3
    done_en = 1'b1;
    send(3, 8'hE3); send(1, 8'hE1);
    expect_byte(1, 8'hE1); expect_byte(3, 8'hE3);
    wait_idle("t5_ptr_reset", 80);
    chk("t5_err_count", err_cnt, 1);

`ifdef UART_ARB_LOCK_EN
    // move pointer to 1, then a locked three-byte packet from req1
    send(0, 8'h50); expect_byte(0, 8'h50);
    wait_idle("t6_prep", 40);
    pq[1].push_back(8'h71); lq[1].push_back(1'b1);
    pq[1].push_back(8'h72); lq[1].push_back(1'b1);
    pq[1].push_back(8'h73); lq[1].push_back(1'b0);
    send(0, 8'h60); send(2, 8'h62);
    expect_byte(1, 8'h71); expect_byte(1, 8'h72); expect_byte(1, 8'h73);
    expect_byte(2, 8'h62); expect_byte(0, 8'h60);
    wait_idle("t6_lock_complete", 200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
